// File: rtl/div_sequencer_if.sv
// Handshake bundle between a controller, the div_sequencer and the clock divider it schedules.
// The slave modport is the sequencer's view; master is the controller/divider side.
interface div_sequencer_if #(
    parameter int AW    = 3,
    parameter int DUR_W = 16
) ();
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [31:0]      wr_factor;
    logic [DUR_W-1:0] wr_dur;
    logic             start;
    logic             stop;
    logic             loop;
    logic             div_clk;
    logic [31:0]      div_factor;
    logic             div_rst_;
    logic             busy;
    logic             done;
    logic [AW-1:0]    idx;

    modport slave (
        input  wr_en, wr_addr, wr_factor, wr_dur, start, stop, loop, div_clk,
        output div_factor, div_rst_, busy, done, idx
    );

    modport master (
        output wr_en, wr_addr, wr_factor, wr_dur, start, stop, loop, div_clk,
        input  div_factor, div_rst_, busy, done, idx
    );
endinterface

// File: rtl/div_sequencer.sv
// Steps a clock divider through a table of (factor, duration) entries, counting divider
// output toggles to time each step. All outputs are registered.
module div_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DUR_W = 16
) (
    input  logic          clk_in,
    input  logic          rst_,
    div_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    // Table is flop-based so that reset can clear every entry to an end marker.
    logic [31:0]      fac_mem_reg [DEPTH];
    logic [DUR_W-1:0] dur_mem_reg [DEPTH];

    always_ff @(posedge clk_in or posedge rst_) begin
        if (rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                fac_mem_reg[i] <= '0;
                dur_mem_reg[i] <= '0;
            end
        end else if (bus.wr_en) begin
            fac_mem_reg[bus.wr_addr] <= bus.wr_factor;
            dur_mem_reg[bus.wr_addr] <= bus.wr_dur;
        end
    end

    logic [1:0]       state_reg,    state_next;
    logic [AW-1:0]    idx_reg,      idx_next;
    logic [31:0]      factor_reg,   factor_next;
    logic [DUR_W-1:0] dur_reg,      dur_next;
    logic [DUR_W-1:0] cnt_reg,      cnt_next;
    logic             clk_prev_reg, clk_prev_next;
    logic             div_rst_reg,  div_rst_next;
    logic             busy_reg,     busy_next;
    logic             done_reg,     done_next;

    // Reading the table combinationally from flops naturally returns the pre-write value.
    logic [31:0]      ent_factor;
    logic [DUR_W-1:0] ent_dur;
    logic [DUR_W-1:0] cnt_inc;

    assign ent_factor = fac_mem_reg[idx_reg];
    assign ent_dur    = dur_mem_reg[idx_reg];
    assign cnt_inc    = cnt_reg + DUR_W'(1);

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        factor_next   = factor_reg;
        dur_next      = dur_reg;
        cnt_next      = cnt_reg;
        clk_prev_next = clk_prev_reg;
        div_rst_next  = div_rst_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_LOAD;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ent_dur != '0) begin
                    // A zero factor would make the divider's terminal count wrap.
                    factor_next   = (ent_factor == 32'd0) ? 32'd1 : ent_factor;
                    dur_next      = ent_dur;
                    cnt_next      = '0;
                    clk_prev_next = 1'b0;
                    div_rst_next  = 1'b1;
                    state_next    = ST_RUN;
                end else if (idx_reg != '0 && bus.loop) begin
                    idx_next = '0;
                end else begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            ST_RUN: begin
                clk_prev_next = bus.div_clk;
                if (bus.div_clk != clk_prev_reg) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == dur_reg) begin
                        div_rst_next = 1'b0;
                        if (idx_reg != LAST_IDX) begin
                            idx_next   = idx_reg + AW'(1);
                            state_next = ST_LOAD;
                        end else if (bus.loop) begin
                            idx_next   = '0;
                            state_next = ST_LOAD;
                        end else begin
                            state_next = ST_IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                div_rst_next = 1'b0;
                busy_next    = 1'b0;
            end
        endcase

        // Abort wins over everything, including a same-cycle start; idx is left where it was.
        if (bus.stop) begin
            state_next   = ST_IDLE;
            idx_next     = idx_reg;
            div_rst_next = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_) begin
        if (rst_) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            factor_reg   <= 32'd1;
            dur_reg      <= '0;
            cnt_reg      <= '0;
            clk_prev_reg <= 1'b0;
            div_rst_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            factor_reg   <= factor_next;
            dur_reg      <= dur_next;
            cnt_reg      <= cnt_next;
            clk_prev_reg <= clk_prev_next;
            div_rst_reg  <= div_rst_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign bus.div_factor = factor_reg;
    assign bus.div_rst_   = div_rst_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.idx        = idx_reg;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural clock divider closing the feedback loop.
module tb_div_sequencer;
    logic clk_in = 1'b0;
    logic rst_   = 1'b1;
    always #5 clk_in = ~clk_in;

    div_sequencer_if #(.AW(3), .DUR_W(16)) bus ();

    div_sequencer #(.DEPTH(8), .AW(3), .DUR_W(16)) dut (
        .clk_in (clk_in),
        .rst_   (rst_),
        .bus    (bus.slave)
    );

    // Divider model: toggles every F cycles after release from reset, output low in reset.
    logic [31:0] mcnt = 32'd0;
    logic        mout = 1'b0;
    always @(posedge clk_in) begin
        if (!bus.div_rst_) begin
            mcnt <= 32'd0;
            mout <= 1'b0;
        end else if (mcnt >= bus.div_factor - 32'd1) begin
            mcnt <= 32'd0;
            mout <= ~mout;
        end else begin
            mcnt <= mcnt + 32'd1;
        end
    end
    assign bus.div_clk = mout;

    int checks   = 0;
    int failures = 0;

    // Per-cycle observations; cycle 0 is the cycle in which start is driven.
    int cyc, nruns, ndone, done_cyc, nbusy, first_busy, last_busy;
    int run_factor [32];
    int run_idx    [32];
    int run_tog    [32];
    logic prev_clk, prev_rst;

    task automatic clear_mon();
        cyc = 0; nruns = 0; ndone = 0; done_cyc = -1;
        nbusy = 0; first_busy = -1; last_busy = -1;
        prev_clk = 1'b0; prev_rst = bus.div_rst_;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        if (bus.div_rst_ && !prev_rst && nruns < 32) begin
            run_factor[nruns] = int'(bus.div_factor);
            run_idx[nruns]    = int'(bus.idx);
            run_tog[nruns]    = 0;
            nruns++;
        end
        if (bus.div_rst_ && bus.div_clk !== prev_clk && nruns > 0) run_tog[nruns-1]++;
        prev_clk = bus.div_rst_ ? bus.div_clk : 1'b0;
        prev_rst = bus.div_rst_;
        if (bus.done) begin ndone++; done_cyc = cyc; end
        if (bus.busy) begin
            nbusy++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
        end
    endtask

    task automatic apply_reset();
        bus.wr_en = 0; bus.start = 0; bus.stop = 0; bus.loop = 0;
        rst_ = 1'b1;
        tick(); tick();
        rst_ = 1'b0;
        tick();
    endtask

    task automatic write_entry(input int addr, input int f, input int d);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 3'(addr);
        bus.wr_factor = 32'(f);
        bus.wr_dur    = 16'(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic kick_start();
        bus.start = 1'b1;
        clear_mon();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ndone > 0) begin ok = 1'b1; break; end
            tick();
        end
        if (ndone > 0) ok = 1'b1;
    endtask

    task automatic wait_runs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (nruns >= n) begin ok = 1'b1; break; end
            tick();
        end
        if (nruns >= n) ok = 1'b1;
    endtask

    task automatic wait_tog(input int run, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (nruns > run && run_tog[run] >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.div_factor !== 32'd1) begin failures++; $display("FAIL reset_factor: got %0d expected 1", bus.div_factor); end
        checks++; if (bus.div_rst_ !== 1'b0) begin failures++; $display("FAIL reset_div_rst: got %b expected 0", bus.div_rst_); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.idx !== 3'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", bus.idx); end
        $display("test_reset: outputs after reset factor=%0d busy=%b", bus.div_factor, bus.busy);
    endtask

    task automatic test_empty();
        write_entry(0, 2, 4);
        apply_reset();
        kick_start();
        checks++; if (bus.busy !== 1'b1 || bus.div_rst_ !== 1'b0) begin failures++; $display("FAIL empty_c1: got busy=%b div_rst_=%b expected busy=1 div_rst_=0", bus.busy, bus.div_rst_); end
        tick();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.div_rst_ !== 1'b0) begin failures++; $display("FAIL empty_c2: got done=%b busy=%b div_rst_=%b expected 1 0 0", bus.done, bus.busy, bus.div_rst_); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL empty_c3_done: got %b expected 0", bus.done); end
        $display("test_empty: done at cycle %0d", done_cyc);
    endtask

    task automatic test_single_step();
        bit ok;
        apply_reset();
        write_entry(0, 2, 4);
        kick_start();
        wait_done(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got no done expected done"); end
        tick(); tick(); tick();
        checks++; if (done_cyc != 12) begin failures++; $display("FAIL single_done_cyc: got %0d expected 12", done_cyc); end
        checks++; if (first_busy != 1 || last_busy != 11 || nbusy != 11) begin failures++; $display("FAIL single_busy: got %0d..%0d n=%0d expected 1..11 n=11", first_busy, last_busy, nbusy); end
        checks++; if (nruns != 1 || run_tog[0] != 4 || run_factor[0] != 2) begin failures++; $display("FAIL single_run: got runs=%0d tog=%0d f=%0d expected 1 4 2", nruns, run_tog[0], run_factor[0]); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL single_ndone: got %0d expected 1", ndone); end
        $display("test_single_step: done_cyc=%0d toggles=%0d", done_cyc, run_tog[0]);
    endtask

    task automatic test_multi_step();
        bit ok;
        int ef [3] = '{3, 1, 5};
        int et [3] = '{2, 2, 1};
        apply_reset();
        write_entry(0, 3, 2);
        write_entry(1, 0, 2);
        write_entry(2, 5, 1);
        kick_start();
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL multi_timeout: got no done expected done"); end
        checks++; if (nruns != 3) begin failures++; $display("FAIL multi_nruns: got %0d expected 3", nruns); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (run_factor[i] != ef[i] || run_tog[i] != et[i] || run_idx[i] != i) begin
                failures++;
                $display("FAIL multi_step%0d: got f=%0d tog=%0d idx=%0d expected f=%0d tog=%0d idx=%0d",
                         i, run_factor[i], run_tog[i], run_idx[i], ef[i], et[i], i);
            end
        end
        checks++; if (bus.idx !== 3'd3 || done_cyc != 21) begin failures++; $display("FAIL multi_end: got idx=%0d done_cyc=%0d expected 3 21", bus.idx, done_cyc); end
        $display("test_multi_step: runs=%0d done_cyc=%0d", nruns, done_cyc);
    endtask

    task automatic test_loop();
        bit ok;
        apply_reset();
        write_entry(0, 3, 2);
        write_entry(1, 0, 2);
        write_entry(2, 5, 1);
        bus.loop = 1'b1;
        kick_start();
        wait_runs(4, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loop_wrap_timeout: got runs=%0d expected 4", nruns); end
        checks++; if (run_idx[3] != 0 || run_factor[3] != 3 || ndone != 0 || cyc != 22) begin failures++; $display("FAIL loop_wrap: got idx=%0d f=%0d done=%0d cyc=%0d expected 0 3 0 22", run_idx[3], run_factor[3], ndone, cyc); end
        bus.loop = 1'b0;
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loop_done_timeout: got no done expected done"); end
        checks++; if (nruns != 6 || run_factor[4] != 1 || run_idx[5] != 2 || done_cyc != 41) begin failures++; $display("FAIL loop_second_pass: got runs=%0d f4=%0d idx5=%0d done_cyc=%0d expected 6 1 2 41", nruns, run_factor[4], run_idx[5], done_cyc); end
        $display("test_loop: runs=%0d done_cyc=%0d", nruns, done_cyc);
    endtask

    task automatic test_full_table();
        bit ok;
        apply_reset();
        for (int i = 0; i < 8; i++) write_entry(i, i + 1, 1);
        kick_start();
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_timeout: got no done expected done"); end
        checks++; if (done_cyc != 53 || bus.idx !== 3'd7) begin failures++; $display("FAIL full_end: got done_cyc=%0d idx=%0d expected 53 7", done_cyc, bus.idx); end
        checks++; if (nruns != 8) begin failures++; $display("FAIL full_nruns: got %0d expected 8", nruns); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (run_factor[i] != i + 1 || run_tog[i] != 1) begin
                failures++;
                $display("FAIL full_step%0d: got f=%0d tog=%0d expected f=%0d tog=1", i, run_factor[i], run_tog[i], i + 1);
            end
        end
        $display("test_full_table: runs=%0d done_cyc=%0d", nruns, done_cyc);
    endtask

    task automatic test_stop();
        bit ok;
        apply_reset();
        write_entry(0, 1, 1);
        write_entry(1, 2, 4);
        kick_start();
        wait_tog(1, 2, 60, ok);
        checks++; if (!ok || cyc != 9) begin failures++; $display("FAIL stop_reach_toggle: got ok=%b cyc=%0d expected 1 9", ok, cyc); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.div_rst_ !== 1'b0 || bus.done !== 1'b0 || bus.idx !== 3'd1) begin failures++; $display("FAIL stop_idle: got busy=%b div_rst_=%b done=%b idx=%0d expected 0 0 0 1", bus.busy, bus.div_rst_, bus.done, bus.idx); end
        tick(); tick(); tick();
        checks++; if (ndone != 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL stop_no_done: got ndone=%0d busy=%b expected 0 0", ndone, bus.busy); end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.div_rst_ !== 1'b0) begin failures++; $display("FAIL start_stop_c1: got busy=%b div_rst_=%b expected 0 0", bus.busy, bus.div_rst_); end
        tick();
        checks++; if (bus.busy !== 1'b0 || ndone != 0) begin failures++; $display("FAIL start_stop_c2: got busy=%b ndone=%0d expected 0 0", bus.busy, ndone); end
        $display("test_stop: stopped at idx=%0d", bus.idx);
    endtask

    task automatic test_active_write();
        bit ok;
        apply_reset();
        write_entry(0, 2, 4);
        bus.loop = 1'b1;
        kick_start();
        wait_tog(0, 1, 30, ok);
        write_entry(0, 3, 2);
        wait_runs(2, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_rerun_timeout: got runs=%0d expected 2", nruns); end
        checks++; if (run_factor[0] != 2 || run_tog[0] != 4) begin failures++; $display("FAIL wr_active_step: got f=%0d tog=%0d expected 2 4", run_factor[0], run_tog[0]); end
        checks++; if (run_factor[1] != 3 || cyc != 13) begin failures++; $display("FAIL wr_next_pass: got f=%0d cyc=%0d expected 3 13", run_factor[1], cyc); end
        bus.loop = 1'b0;
        wait_done(60, ok);
        checks++; if (!ok || run_tog[1] != 2 || nruns != 2) begin failures++; $display("FAIL wr_end: got ok=%b tog=%0d runs=%0d expected 1 2 2", ok, run_tog[1], nruns); end
        $display("test_active_write: second pass factor=%0d toggles=%0d", run_factor[1], run_tog[1]);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_factor = '0; bus.wr_dur = '0;
        bus.start = 0; bus.stop = 0; bus.loop = 0;
        clear_mon();
        test_reset();
        test_empty();
        test_single_step();
        test_multi_step();
        test_loop();
        test_full_table();
        test_stop();
        test_active_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
